// File: rtl/adc_spi_responder.sv
// MCP3202-style 2-channel SPI ADC emulator (slave side).
// The SPI pins are oversampled in the int_clk domain. Conversion results
// come from the ch0_sample/ch1_sample inputs instead of a real converter.
module adc_spi_responder #(
    parameter int   DATA_W      = 12,
    parameter int   SYNC_STAGES = 2,
    parameter logic DOUT_IDLE   = 1'b0
) (
    input  logic              int_clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              read_clk,
    input  logic              din,
    input  logic [DATA_W-1:0] ch0_sample,
    input  logic [DATA_W-1:0] ch1_sample,
    output logic              dout,
    output logic              busy,
    output logic              channel,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_CFG, S_NULL, S_DATA, S_LSBF, S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, rck_sync_q, din_sync_q;
    logic                   cs_prev_q, rck_prev_q;

    state_t              state_q, state_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                channel_q, channel_d;
    logic                msbf_q, msbf_d;
    logic                dout_q, dout_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic cs_s, rck_s, din_s;
    logic cs_fall, cs_rise, rck_rise, rck_fall;

    // Pin synchronizers plus one history flop per edge-detected pin.
    // Reset values match an idle bus: cs high, read_clk low.
    always_ff @(posedge int_clk) begin
        if (rst) begin
            cs_sync_q  <= '1;
            rck_sync_q <= '0;
            din_sync_q <= '0;
            cs_prev_q  <= 1'b1;
            rck_prev_q <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            rck_sync_q <= {rck_sync_q[SYNC_STAGES-2:0], read_clk};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
            cs_prev_q  <= cs_s;
            rck_prev_q <= rck_s;
        end
    end

    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign rck_s = rck_sync_q[SYNC_STAGES-1];
    assign din_s = din_sync_q[SYNC_STAGES-1];

    assign cs_fall  = ~cs_s &  cs_prev_q;
    assign cs_rise  =  cs_s & ~cs_prev_q;
    // Clock edges only count while the slave is selected
    assign rck_rise =  rck_s & ~rck_prev_q & ~cs_s;
    assign rck_fall = ~rck_s &  rck_prev_q & ~cs_s;

    // Frame state register and registered outputs
    always_ff @(posedge int_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            channel_q <= 1'b0;
            msbf_q    <= 1'b0;
            dout_q    <= DOUT_IDLE;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            channel_q <= channel_d;
            msbf_q    <= msbf_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic; a cs rise overrides any read_clk edge
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        channel_d = channel_q;
        msbf_d    = msbf_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (cs_rise) begin
            state_d = S_IDLE;
            dout_d  = DOUT_IDLE;
            err_d   = (state_q == S_CFG) || (state_q == S_NULL) ||
                      (state_q == S_DATA) || (state_q == S_LSBF);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall) state_d = S_WAIT_START;
                end
                S_WAIT_START: begin
                    // leading zeros before the start bit are skipped
                    if (rck_rise && din_s) begin
                        state_d   = S_CFG;
                        bit_cnt_d = '0;
                    end
                end
                S_CFG: begin
                    // bit 0 = SGL/DIFF (consumed, no effect on returned data),
                    // bit 1 = ODD/SIGN, bit 2 = MSBF
                    if (rck_rise) begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        if (bit_cnt_q == CW'(1)) begin
                            channel_d = din_s;
                            shift_d   = din_s ? ch1_sample : ch0_sample;
                        end else if (bit_cnt_q == CW'(2)) begin
                            msbf_d  = din_s;
                            state_d = S_NULL;
                        end
                    end
                end
                S_NULL: begin
                    if (rck_fall) begin
                        dout_d    = 1'b0;
                        state_d   = S_DATA;
                        bit_cnt_d = CW'(DATA_W-1);
                    end
                end
                S_DATA: begin
                    if (rck_fall) begin
                        dout_d = shift_q[bit_cnt_q];
                        if (bit_cnt_q == '0) begin
                            if (msbf_q) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d   = S_LSBF;
                                bit_cnt_d = CW'(1);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - CW'(1);
                        end
                    end
                end
                S_LSBF: begin
                    // bit 0 was already sent as the last MSB-first bit
                    if (rck_fall) begin
                        dout_d = shift_q[bit_cnt_q];
                        if (bit_cnt_q == CW'(DATA_W-1)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (rck_fall) dout_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign busy       = (state_q != S_IDLE);
    assign channel    = channel_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: table of full frames plus
// hand-written abort and mid-frame reset sequences.
module tb_adc_spi_responder;

    localparam int HALF = 5;   // int_clk cycles per read_clk phase (10x)

    logic        int_clk;
    logic        rst, cs, read_clk, din;
    logic [11:0] ch0_sample, ch1_sample;
    logic        dout, busy, channel, frame_done, frame_err;

    int n_chk = 0, n_fail = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;

    adc_spi_responder #(.DATA_W(12), .SYNC_STAGES(2), .DOUT_IDLE(1'b0)) dut (
        .int_clk(int_clk), .rst(rst), .cs(cs), .read_clk(read_clk), .din(din),
        .ch0_sample(ch0_sample), .ch1_sample(ch1_sample), .dout(dout),
        .busy(busy), .channel(channel), .frame_done(frame_done),
        .frame_err(frame_err)
    );

    initial int_clk = 1'b0;
    always #5 int_clk = ~int_clk;

    // pulse counters: each cycle a pulse is high adds one
    always @(negedge int_clk) begin
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (frame_done && frame_err) both_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [11:0] c0, c1, c0_new;
        logic        chg, sgl, odd, msbf;
        int          lead;
        logic [11:0] exp_msb;
        logic [10:0] exp_lsb;   // bits 1..11 in LSB-first tail
        logic        exp_ch;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one read_clk pulse; q is dout as seen by the master at the rise
    task automatic pulse(input logic d, output logic q);
        din = d;
        repeat (HALF) @(negedge int_clk);
        q = dout;
        read_clk = 1'b1;
        repeat (HALF) @(negedge int_clk);
        read_clk = 1'b0;
    endtask

    task automatic start_cfg(input int lead, input logic sgl, input logic odd, input logic msbf);
        logic q;
        cs = 1'b0;
        repeat (4) @(negedge int_clk);
        for (int i = 0; i < lead; i++) pulse(1'b0, q);
        pulse(1'b1, q);
        pulse(sgl, q);
        pulse(odd, q);
        pulse(msbf, q);
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        logic q;
        logic [11:0] w;
        logic [10:0] l;
        int d0, e0;
        w = '0; l = '0;
        ch0_sample = v.c0; ch1_sample = v.c1;
        d0 = done_cnt; e0 = err_cnt;
        start_cfg(v.lead, v.sgl, v.odd, v.msbf);
        check($sformatf("v%0d busy", idx), {31'd0, busy}, 32'd1);
        if (v.chg) ch0_sample = v.c0_new;
        pulse(1'b0, q);
        check($sformatf("v%0d null", idx), {31'd0, q}, 32'd0);
        for (int b = 11; b >= 0; b--) begin
            pulse(1'b0, q);
            w[b] = q;
        end
        if (!v.msbf) begin
            for (int b = 0; b < 11; b++) begin
                pulse(1'b0, q);
                l[b] = q;
            end
        end
        check($sformatf("v%0d word", idx), {20'd0, w}, {20'd0, v.exp_msb});
        if (!v.msbf)
            check($sformatf("v%0d lsbf", idx), {21'd0, l}, {21'd0, v.exp_lsb});
        check($sformatf("v%0d done", idx), done_cnt - d0, 32'd1);
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0, q);
            check($sformatf("v%0d overclk dout", idx), {31'd0, q}, 32'd0);
        end
        repeat (HALF) @(negedge int_clk);
        check($sformatf("v%0d done after overclk", idx), done_cnt - d0, 32'd1);
        cs = 1'b1;
        repeat (6) @(negedge int_clk);
        check($sformatf("v%0d busy end", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d dout idle", idx), {31'd0, dout}, 32'd0);
        check($sformatf("v%0d channel", idx), {31'd0, channel}, {31'd0, v.exp_ch});
        check($sformatf("v%0d no err", idx), err_cnt - e0, 32'd0);
    endtask

    initial begin
        logic q;
        int d0, e0;

        vecs[0] = '{c0:12'hA5C, c1:12'h000, c0_new:12'h000, chg:0, sgl:1, odd:0, msbf:1,
                    lead:0, exp_msb:12'hA5C, exp_lsb:11'h000, exp_ch:0};
        vecs[1] = '{c0:12'h000, c1:12'h3C1, c0_new:12'h000, chg:0, sgl:1, odd:1, msbf:0,
                    lead:0, exp_msb:12'h3C1, exp_lsb:11'h1E0, exp_ch:1};
        vecs[2] = '{c0:12'h123, c1:12'hFFF, c0_new:12'hFFF, chg:1, sgl:1, odd:0, msbf:1,
                    lead:3, exp_msb:12'h123, exp_lsb:11'h000, exp_ch:0};
        vecs[3] = '{c0:12'h000, c1:12'h5A5, c0_new:12'h000, chg:0, sgl:0, odd:1, msbf:1,
                    lead:1, exp_msb:12'h5A5, exp_lsb:11'h000, exp_ch:1};
        vecs[4] = '{c0:12'hFFF, c1:12'h000, c0_new:12'h000, chg:0, sgl:1, odd:0, msbf:0,
                    lead:0, exp_msb:12'hFFF, exp_lsb:11'h7FF, exp_ch:0};
        vecs[5] = '{c0:12'hFFF, c1:12'h000, c0_new:12'h000, chg:0, sgl:1, odd:1, msbf:1,
                    lead:2, exp_msb:12'h000, exp_lsb:11'h000, exp_ch:1};

        rst = 1'b1; cs = 1'b1; read_clk = 1'b0; din = 1'b0;
        ch0_sample = '0; ch1_sample = '0;
        repeat (3) @(negedge int_clk);
        check("reset dout", {31'd0, dout}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset channel", {31'd0, channel}, 32'd0);
        check("reset done", {31'd0, frame_done}, 32'd0);
        check("reset err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge int_clk);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // abort: cs rises after 5 data bits of an MSB-first channel 0 frame
        ch0_sample = 12'hA5C;
        d0 = done_cnt; e0 = err_cnt;
        start_cfg(0, 1'b1, 1'b0, 1'b1);
        pulse(1'b0, q);
        for (int i = 0; i < 5; i++) pulse(1'b0, q);
        repeat (HALF) @(negedge int_clk);
        cs = 1'b1;
        repeat (6) @(negedge int_clk);
        check("abort err pulse", err_cnt - e0, 32'd1);
        check("abort no done", done_cnt - d0, 32'd0);
        check("abort dout", {31'd0, dout}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        run_frame(vecs[0], 10);

        // reset during DATA of a channel 1 frame (dout is 1 at that point)
        ch1_sample = 12'h3C1;
        e0 = err_cnt;
        start_cfg(0, 1'b1, 1'b1, 1'b1);
        pulse(1'b0, q);
        for (int i = 0; i < 3; i++) pulse(1'b0, q);
        repeat (3) @(negedge int_clk);
        check("pre-reset dout", {31'd0, dout}, 32'd1);
        rst = 1'b1;
        @(negedge int_clk);
        rst = 1'b0;
        check("mid rst dout", {31'd0, dout}, 32'd0);
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst channel", {31'd0, channel}, 32'd0);
        check("mid rst done", {31'd0, frame_done}, 32'd0);
        check("mid rst err", {31'd0, frame_err}, 32'd0);
        repeat (4) @(negedge int_clk);
        cs = 1'b1;
        repeat (6) @(negedge int_clk);
        check("mid rst no err", err_cnt - e0, 32'd0);
        run_frame(vecs[1], 11);

        check("done/err overlap", both_cnt, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
